// File: rtl/param_up_down_counter_pkg.sv
// +----------------------------------------------------------------------+
// | counter_pkg: shared types and constants for param_up_down_counter    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEFAULT_COUNTER_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/param_up_down_counter_if.sv
// +----------------------------------------------------------------------+
// | param_up_down_counter_if: control/status bundle of the counter       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface param_up_down_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_COUNTER_WIDTH
);

  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit_lo;
  logic [WIDTH-1:0] limit_hi;
  logic             sat_mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             cfg_err;

  modport master (
    output enable, up_down, load, data_in, step, limit_lo, limit_hi, sat_mode,
    input  count, tc, cfg_err
  );

  modport slave (
    input  enable, up_down, load, data_in, step, limit_lo, limit_hi, sat_mode,
    output count, tc, cfg_err
  );

endinterface

`default_nettype wire

// File: rtl/param_up_down_counter_step_unit.sv
// +----------------------------------------------------------------------+
// | counter_step_unit: next-count / terminal-count and load clamp logic  |
// | Macro COUNTER_SATURATE_EN enables saturate mode.  Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module counter_step_unit
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  wire logic [WIDTH-1:0] count,
  input  wire dir_e             dir,
  input  wire logic [WIDTH-1:0] step,
  input  wire logic [WIDTH-1:0] limit_lo,
  input  wire logic [WIDTH-1:0] limit_hi,
  input  wire logic             sat_mode,
  input  wire logic [WIDTH-1:0] data_in,
  output logic      [WIDTH-1:0] step_val,
  output logic                  step_tc,
  output logic      [WIDTH-1:0] load_val
);

  logic        [WIDTH:0]   sum;
  logic signed [WIDTH:0]   diff;
  logic                    bound_evt;
  logic        [WIDTH-1:0] wrap_val;
  logic        [WIDTH-1:0] sat_val;

`ifndef COUNTER_SATURATE_EN
  wire w_unused_sat = sat_mode ^ (|sat_val);
`endif

  always_comb begin
    sum       = {1'b0, count} + {1'b0, step};
    diff      = $signed({1'b0, count}) - $signed({1'b0, step});
    step_val  = count;
    step_tc   = 1'b0;
    bound_evt = 1'b0;
    wrap_val  = count;
    sat_val   = count;

    // A zero step never fires an event, even when count sits outside the bounds.
    if (step != '0) begin
      if (dir == DIR_UP) begin
        if (sum <= {1'b0, limit_hi}) begin
          step_val = sum[WIDTH-1:0];
        end else begin
          bound_evt = 1'b1;
          wrap_val  = limit_lo;
          sat_val   = limit_hi;
        end
      end else begin
        if (diff >= $signed({1'b0, limit_lo})) begin
          step_val = diff[WIDTH-1:0];
        end else begin
          bound_evt = 1'b1;
          wrap_val  = limit_hi;
          sat_val   = limit_lo;
        end
      end
    end

    if (bound_evt) begin
`ifdef COUNTER_SATURATE_EN
      if (sat_mode) begin
        // Already parked at the bound: hold quietly so tc never repeats.
        if (count != sat_val) begin
          step_val = sat_val;
          step_tc  = 1'b1;
        end
      end else begin
        step_val = wrap_val;
        step_tc  = 1'b1;
      end
`else
      step_val = wrap_val;
      step_tc  = 1'b1;
`endif
    end
  end

  always_comb begin
    load_val = data_in;
    if (data_in < limit_lo) begin
      load_val = limit_lo;
    end else if (data_in > limit_hi) begin
      load_val = limit_hi;
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_up_down_counter.sv
// +----------------------------------------------------------------------+
// | param_up_down_counter: bounded up/down counter with load and tc      |
// | Macro COUNTER_SATURATE_EN enables saturate mode.  Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module param_up_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_COUNTER_WIDTH,
  parameter int RESET_VAL = 0
) (
  input wire logic              clk,
  input wire logic              rst,
  param_up_down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] C_RESET_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] step_val;
  logic             step_tc;
  logic [WIDTH-1:0] load_val;

  counter_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .count    (count_q),
    .dir      (dir_e'(bus.up_down)),
    .step     (bus.step),
    .limit_lo (bus.limit_lo),
    .limit_hi (bus.limit_hi),
    .sat_mode (bus.sat_mode),
    .data_in  (bus.data_in),
    .step_val (step_val),
    .step_tc  (step_tc),
    .load_val (load_val)
  );

  // Invalid bounds freeze the counter and mask load/enable.
  always_comb begin
    cfg_err_d = (bus.limit_lo > bus.limit_hi);
    count_d   = count_q;
    tc_d      = 1'b0;
    if (!cfg_err_d) begin
      if (bus.load) begin
        count_d = load_val;
      end else if (bus.enable) begin
        count_d = step_val;
        tc_d    = step_tc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= C_RESET_VAL;
      tc_q      <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tc_q      <= tc_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.cfg_err = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_param_up_down_counter.sv
// +----------------------------------------------------------------------+
// | tb_param_up_down_counter: directed self-checking bench (WIDTH=8)     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_param_up_down_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  param_up_down_counter_if #(.WIDTH(8)) bus ();

  param_up_down_counter #(
    .WIDTH     (8),
    .RESET_VAL (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 0; bus.up_down = 0; bus.load = 0; bus.data_in = 0;
    bus.step = 1; bus.limit_lo = 0; bus.limit_hi = 8'd255; bus.sat_mode = 0;
    tick(); tick();
    n_tests++;
    if (bus.count !== 8'd5 || bus.tc !== 1'b0 || bus.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: count=%0d tc=%b err=%b expected 5 0 0", bus.count, bus.tc, bus.cfg_err);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (bus.count !== 8'd5 || bus.tc !== 1'b0 || bus.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: count=%0d tc=%b err=%b expected 5 0 0", bus.count, bus.tc, bus.cfg_err);
    end
  endtask

  task automatic test_load_clamp();
    bus.limit_lo = 8'd10; bus.limit_hi = 8'd20;
    bus.load = 1; bus.data_in = 8'd3;
    tick();
    n_tests++;
    if (bus.count !== 8'd10 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load_low: count=%0d tc=%b expected 10 0", bus.count, bus.tc);
    end
    bus.data_in = 8'd250;
    tick();
    n_tests++;
    if (bus.count !== 8'd20 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load_high: count=%0d tc=%b expected 20 0", bus.count, bus.tc);
    end
    bus.data_in = 8'd15;
    tick();
    n_tests++;
    if (bus.count !== 8'd15) begin
      n_fail++;
      $display("FAIL load_in_range: count=%0d expected 15", bus.count);
    end
    bus.load = 0;
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_c [4] = '{8'd4, 8'd8, 8'd0, 8'd4};
    logic       exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bus.limit_lo = 0; bus.limit_hi = 8'd9; bus.step = 8'd4; bus.sat_mode = 0;
    bus.load = 1; bus.data_in = 0;
    tick();
    bus.load = 0; bus.enable = 1; bus.up_down = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.count !== exp_c[i] || bus.tc !== exp_t[i]) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: count=%0d tc=%b expected %0d %b", i, bus.count, bus.tc, exp_c[i], exp_t[i]);
      end
    end
    bus.enable = 0;
    tick();
    n_tests++;
    if (bus.count !== 8'd4 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_low_hold: count=%0d tc=%b expected 4 0", bus.count, bus.tc);
    end
  endtask

  task automatic test_wrap_down();
    logic [7:0] exp_c [5] = '{8'd12, 8'd9, 8'd6, 8'd3, 8'd12};
    logic       exp_t [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.limit_lo = 8'd2; bus.limit_hi = 8'd12; bus.step = 8'd3;
    bus.load = 1; bus.data_in = 8'd4;
    tick();
    bus.load = 0; bus.enable = 1; bus.up_down = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (bus.count !== exp_c[i] || bus.tc !== exp_t[i]) begin
        n_fail++;
        $display("FAIL wrap_down[%0d]: count=%0d tc=%b expected %0d %b", i, bus.count, bus.tc, exp_c[i], exp_t[i]);
      end
    end
    // 2 - 3 goes below zero: must be seen as underflow, not as 255
    bus.enable = 0; bus.load = 1; bus.data_in = 8'd2;
    tick();
    bus.load = 0; bus.enable = 1;
    tick();
    n_tests++;
    if (bus.count !== 8'd12 || bus.tc !== 1'b1) begin
      n_fail++;
      $display("FAIL down_below_zero: count=%0d tc=%b expected 12 1", bus.count, bus.tc);
    end
    bus.enable = 0;
  endtask

  task automatic test_back_to_back();
    bus.limit_lo = 8'd3; bus.limit_hi = 8'd3; bus.step = 8'd1; bus.up_down = 0;
    bus.load = 1; bus.data_in = 8'd3;
    tick();
    bus.load = 0; bus.enable = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (bus.count !== 8'd3 || bus.tc !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_tc_consecutive[%0d]: count=%0d tc=%b expected 3 1", i, bus.count, bus.tc);
      end
    end
    bus.step = 0;
    tick();
    n_tests++;
    if (bus.count !== 8'd3 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL step_zero_hold: count=%0d tc=%b expected 3 0", bus.count, bus.tc);
    end
    bus.enable = 0;
  endtask

  task automatic test_saturate();
    logic [7:0] exp_c0, exp_c1;
    logic       exp_t0;
`ifdef COUNTER_SATURATE_EN
    exp_c0 = 8'd12; exp_t0 = 1'b1; exp_c1 = 8'd12;
`else
    exp_c0 = 8'd0;  exp_t0 = 1'b1; exp_c1 = 8'd5;
`endif
    bus.limit_lo = 0; bus.limit_hi = 8'd12; bus.step = 8'd5; bus.up_down = 0;
    bus.sat_mode = 1; bus.load = 1; bus.data_in = 8'd10;
    tick();
    bus.load = 0; bus.enable = 1;
    tick();
    n_tests++;
    if (bus.count !== exp_c0 || bus.tc !== exp_t0) begin
      n_fail++;
      $display("FAIL sat_first: count=%0d tc=%b expected %0d %b", bus.count, bus.tc, exp_c0, exp_t0);
    end
    tick();
    n_tests++;
    if (bus.count !== exp_c1 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_second: count=%0d tc=%b expected %0d 0", bus.count, bus.tc, exp_c1);
    end
    bus.enable = 0; bus.sat_mode = 0;
  endtask

  task automatic test_cfg_err();
    bus.limit_lo = 8'd30; bus.limit_hi = 8'd40; bus.step = 8'd1; bus.up_down = 0;
    bus.load = 1; bus.data_in = 8'd35;
    tick();
    bus.load = 0;
    bus.limit_hi = 8'd20; bus.enable = 1;
    tick();
    n_tests++;
    if (bus.count !== 8'd35 || bus.tc !== 1'b0 || bus.cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_set: count=%0d tc=%b err=%b expected 35 0 1", bus.count, bus.tc, bus.cfg_err);
    end
    bus.load = 1; bus.data_in = 8'd25;
    tick();
    n_tests++;
    if (bus.count !== 8'd35 || bus.cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_load_ignored: count=%0d err=%b expected 35 1", bus.count, bus.cfg_err);
    end
    bus.load = 0; bus.limit_hi = 8'd40;
    tick();
    n_tests++;
    if (bus.count !== 8'd36 || bus.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_clear: count=%0d err=%b expected 36 0", bus.count, bus.cfg_err);
    end
    tick();
    n_tests++;
    if (bus.count !== 8'd37) begin
      n_fail++;
      $display("FAIL resume_count: count=%0d expected 37", bus.count);
    end
    rst = 1'b1; bus.load = 1; bus.data_in = 8'd33;
    tick();
    n_tests++;
    if (bus.count !== 8'd5 || bus.tc !== 1'b0 || bus.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_count: count=%0d tc=%b err=%b expected 5 0 0", bus.count, bus.tc, bus.cfg_err);
    end
    rst = 1'b0; bus.load = 0; bus.enable = 0;
  endtask

  initial begin
    test_reset();
    test_load_clamp();
    test_wrap_up();
    test_wrap_down();
    test_back_to_back();
    test_saturate();
    test_cfg_err();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
